// File: rtl/apb_initiator_pkg.sv
// rtl/apb_initiator_pkg.sv - shared state encoding and defaults for the APB initiator
package apb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_init_state_t;

    localparam int APB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/apb_timeout_ctr.sv
// rtl/apb_timeout_ctr.sv - ACCESS wait-state counter with expiry flag (used under APB_TIMEOUT_EN)
module apb_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    // Expiry is flagged in the cycle that would be the LIMIT-th stalled ACCESS cycle.
    assign expired = tick && (count == LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - APB4 requester FSM; optional ACCESS timeout via APB_TIMEOUT_EN
module apb_initiator
    import apb_initiator_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic [ADDR_W-1:0]   ReqAddr,
    input  logic                ReqWrite,
    input  logic [XLEN-1:0]     ReqWData,
    input  logic [XLEN/8-1:0]   ReqStrb,
    output logic                RspValid,
    input  logic                RspReady,
    output logic [XLEN-1:0]     RspRData,
    output logic                RspErr,
    output logic                PSEL,
    output logic                PENABLE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [XLEN-1:0]     PWDATA,
    output logic [XLEN/8-1:0]   PSTRB,
    input  logic [XLEN-1:0]     PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    apb_init_state_t state;
    logic            accept;
    logic            timeout_hit;

    assign ReqReady = (state == IDLE) | ((state == RESP) & RspReady);
    assign accept   = ReqValid & ReqReady;

`ifdef APB_TIMEOUT_EN
    logic ctr_clear;
    logic ctr_tick;

    assign ctr_clear = (state == SETUP);
    assign ctr_tick  = (state == ACCESS) && !PREADY;

    apb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (ctr_clear),
        .tick    (ctr_tick),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PADDR    <= '0;
            PWRITE   <= 1'b0;
            PWDATA   <= '0;
            PSTRB    <= '0;
            RspValid <= 1'b0;
            RspRData <= '0;
            RspErr   <= 1'b0;
        end else begin
            case (state)
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // A PREADY coinciding with timeout expiry completes normally.
                    if (PREADY) begin
                        PSEL     <= 1'b0;
                        PENABLE  <= 1'b0;
                        RspValid <= 1'b1;
                        RspErr   <= PSLVERR;
                        RspRData <= PWRITE ? '0 : PRDATA;
                        state    <= RESP;
                    end else if (timeout_hit) begin
                        PSEL     <= 1'b0;
                        PENABLE  <= 1'b0;
                        RspValid <= 1'b1;
                        RspErr   <= 1'b1;
                        RspRData <= '0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                end
            endcase

            // Accept overrides the RESP->IDLE path so back-to-back transfers skip the idle cycle.
            if (accept) begin
                PADDR  <= ReqAddr;
                PWRITE <= ReqWrite;
                PWDATA <= ReqWrite ? ReqWData : '0;
                PSTRB  <= ReqWrite ? ReqStrb : '0;
                PSEL   <= 1'b1;
                state  <= SETUP;
            end
        end
    end

endmodule
